sram_2147_ctrl: RTL and testbench
=================================

// Module: sram_2147_ctrl
// PURPOSE
//  Synchronous initiator for a bank of 2147-style 4k x 1 static RAMs (one part per data bit).
//  Converts a CPU-side valid/ready request into address/CE_N/WE_N/DI sequencing with programmable
//  setup, strobe and hold phases. Samples the parts' DO outputs and returns read data and write acks.
//  Sits between CADR memory-path logic and the RAM array.
// PARAMETERS
//  DATA_W    32  data bits, equal to the number of 2147 parts in the bank
//  ADDR_W    12  address bits, matching the 2147 depth of 4096
//  T_SETUP   1   cycles address/DI are stable before the strobe; legal range 1..15
//  T_STROBE  2   cycles CE_N is low; DO is sampled on the last one; legal range 1..15
//  T_HOLD    1   cycles address/DI are held after the strobe; legal range 1..15
// PORTS
//  clk        in   1        single clock; all state changes on its rising edge
//  reset      in   1        synchronous, active-high reset
//  req_valid  in   1        request present
//  req_ready  out  1        request accepted on a cycle where valid&ready are both 1
//  req_we     in   1        1 = write, 0 = read
//  req_addr   in   ADDR_W   word address
//  req_wdata  in   DATA_W   write data
//  rsp_valid  out  1        one-cycle pulse completing each accepted request
//  rsp_rdata  out  DATA_W   read data; 0 for writes
//  rsp_err    out  1        parity error on a read; valid with rsp_valid
//  ram_a      out  ADDR_W   shared address to all parts
//  ram_ce_n   out  1        shared chip enable, active low
//  ram_we_n   out  1        shared write enable, active low
//  ram_di     out  RAM_W    per-part data in
//  ram_do     in   RAM_W    per-part data out; high-Z while ram_ce_n=1
// BEHAVIOUR
//  - Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_ce_n=1, ram_we_n=1,
//    ram_a=0, ram_di=0.
//  - FSM states: IDLE -> SETUP (T_SETUP cycles) -> STROBE (T_STROBE cycles) -> HOLD (T_HOLD cycles) -> IDLE.
//  - req_ready=1 only in IDLE. The accept edge registers we, addr and wdata.
//    ram_a and ram_di then hold these values unchanged through SETUP, STROBE and HOLD.
//  - STROBE: ram_ce_n=0. ram_we_n=0 for writes; ram_we_n=1 for reads.
//    ram_we_n falls and rises on the same edges as ram_ce_n.
//    ram_ce_n and ram_we_n are 1 in every other state.
//  - Reads: ram_do is registered at the clock edge ending the last STROBE cycle.
//    ram_do is never sampled while ram_ce_n=1; X/Z there is don't-care.
//  - rsp_valid pulses for one cycle in the first HOLD cycle, for both reads and writes.
//    Accept edge to rsp_valid = T_SETUP+T_STROBE+1 cycles (4 at defaults).
//  - Repeat rate: one operation per T_SETUP+T_STROBE+T_HOLD+1 cycles (5 at defaults).
//    No overlap and no pipelining; requests with req_valid held high are served back-to-back.
//  - Phase counter: 4 bits, loaded with (T_x - 1) on each phase entry, decremented each cycle.
//    Phase exits when the counter is 0. No wrap is possible.
//  - Parameters outside 1..15 are an elaboration-time error.
//  - Address 0 and address 2^ADDR_W-1 need no special handling; no address increment exists.
//  - Reset mid-operation: next edge forces IDLE, ram_ce_n=ram_we_n=1 and rsp_valid=0; the operation is dropped.
//    A write interrupted in STROBE may already have updated the parts; no response is issued.
// CONFIGURATION
//  SRAM_PARITY_EN defined:
//   - RAM_W = DATA_W+1.
//   - ram_di[DATA_W] = ~^req_wdata, giving odd parity over DATA_W+1 bits.
//   - On reads, rsp_err = ^ram_do sampled == 0 (even total = error). rsp_err=0 on writes.
//  SRAM_PARITY_EN undefined: RAM_W = DATA_W and rsp_err is tied to 0.
// STRUCTURE
//  - Package sram_2147_pkg: state enum {IDLE,SETUP,STROBE,HOLD}, default T_* constants,
//    2147 depth constant 4096, 4-bit counter width.
//  - Sub-module sram_2147_phase_timer: loadable 4-bit down-counter with a done output; one instance.
// TESTING
//  Bench uses DATA_W part_2147 models (DATA_W+1 with parity) on the ram_* bus.
//  1 Reset held 3 cycles -> ce_n=we_n=1, req_ready=1, rsp_valid=0, ram_a=0.
//  2 Write 0xDEADBEEF @0x123, then read @0x123 ->
//    ce_n low exactly 2 cycles each op; we_n low only during the write strobe;
//    rsp_valid 4 cycles after each accept edge; rsp_rdata=0xDEADBEEF.
//  3 Write 0xA5A5A5A5 @0xFFF and 0x5A5A5A5A @0x000, then read both -> each value returned unaliased.
//  4 req_valid held high for 3 reads -> accepts at cycles 0, 5, 10; req_ready=0 in between.
//  5 Reset asserted in the 2nd STROBE cycle of a read -> next cycle ce_n=1, req_ready=1; no rsp_valid ever.
//  6 SRAM_PARITY_EN: write 0x00000001 -> ram_di[32]=0; bench flips that stored bit;
//    read -> rsp_err=1. Without the macro, rsp_err stays 0.

Source files
------------

// File: rtl/sram_2147_pkg.sv
// Shared types and constants for the 2147 SRAM bank controller.
// SRAM_PARITY_EN adds one odd-parity part to the bank.
package sram_2147_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam int CNT_W       = 4;
    localparam int DEPTH_2147  = 4096;
    localparam int T_SETUP_DEF  = 1;
    localparam int T_STROBE_DEF = 2;
    localparam int T_HOLD_DEF   = 1;

`ifdef SRAM_PARITY_EN
    localparam int PARITY_W = 1;
`else
    localparam int PARITY_W = 0;
`endif

    // A phase of t cycles starts with the counter at t-1 and ends when it reads zero.
    function automatic logic [CNT_W-1:0] phase_load(input int t);
        return CNT_W'(t - 1);
    endfunction

endpackage

// File: rtl/sram_2147_phase_timer.sv
// Loadable down-counter timing one controller phase; done is high while the count is zero.
module sram_2147_phase_timer
    import sram_2147_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/sram_2147_ctrl.sv
// Initiator for a bank of 2147 4k x 1 SRAMs: one request at a time, setup/strobe/hold sequencing.
// Defining SRAM_PARITY_EN adds an odd-parity part and reports read parity errors on rsp_err.
module sram_2147_ctrl
    import sram_2147_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int ADDR_W   = 12,
    parameter  int T_SETUP  = T_SETUP_DEF,
    parameter  int T_STROBE = T_STROBE_DEF,
    parameter  int T_HOLD   = T_HOLD_DEF,
    localparam int RAM_W    = DATA_W + PARITY_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_ce_n,
    output logic              ram_we_n,
    output logic [RAM_W-1:0]  ram_di,
    input  logic [RAM_W-1:0]  ram_do
);

    if (T_SETUP < 1 || T_SETUP > 15 || T_STROBE < 1 || T_STROBE > 15 ||
        T_HOLD < 1 || T_HOLD > 15 || (1 << ADDR_W) != DEPTH_2147) begin : g_param_check
        $error("sram_2147_ctrl: phase lengths must be 1..15 and ADDR_W must span the 2147 depth");
    end

    state_t           state;
    logic             op_we;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_done;
    logic [RAM_W-1:0] di_next;
    logic             parity_bad;

`ifdef SRAM_PARITY_EN
    assign di_next    = {~^req_wdata, req_wdata};
    assign parity_bad = ~^ram_do;
`else
    assign di_next    = req_wdata;
    assign parity_bad = 1'b0;
`endif

    // The timer is reloaded on the same edge that moves the FSM into the next phase.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        case (state)
            IDLE:   if (req_valid && req_ready) begin
                        timer_load = 1'b1;
                        timer_val  = phase_load(T_SETUP);
                    end
            SETUP:  if (timer_done) begin
                        timer_load = 1'b1;
                        timer_val  = phase_load(T_STROBE);
                    end
            STROBE: if (timer_done) begin
                        timer_load = 1'b1;
                        timer_val  = phase_load(T_HOLD);
                    end
            default: ;
        endcase
    end

    sram_2147_phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_we     <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ram_a     <= '0;
            ram_ce_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram_di    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    state     <= SETUP;
                    req_ready <= 1'b0;
                    op_we     <= req_we;
                    ram_a     <= req_addr;
                    ram_di    <= di_next;
                end
                SETUP: if (timer_done) begin
                    state    <= STROBE;
                    ram_ce_n <= 1'b0;
                    ram_we_n <= ~op_we;
                end
                // ram_do is only valid here, while the parts are still enabled.
                STROBE: if (timer_done) begin
                    state     <= HOLD;
                    ram_ce_n  <= 1'b1;
                    ram_we_n  <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= op_we ? '0 : ram_do[DATA_W-1:0];
                    rsp_err   <= ~op_we & parity_bad;
                end
                HOLD: if (timer_done) begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_2147_ctrl.sv
// Bench for sram_2147_ctrl: behavioural RAM bank, vector table, random traffic and corner sequences.
// Build with SRAM_PARITY_EN defined to exercise the parity part.
module tb_sram_2147_ctrl;
    import sram_2147_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 12;
    localparam int RAM_W  = DATA_W + PARITY_W;
    localparam int T_S    = 1;
    localparam int T_ST   = 2;
    localparam int T_H    = 1;
    localparam int LAT    = T_S + T_ST + 1;
    localparam int PERIOD = T_S + T_ST + T_H + 1;
    localparam logic [RAM_W-1:0] INIT_WORD = (PARITY_W == 1) ? {1'b1, {(RAM_W-1){1'b0}}} : '0;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_ce_n;
    logic              ram_we_n;
    logic [RAM_W-1:0]  ram_di;
    logic [RAM_W-1:0]  ram_do;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    sram_2147_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .T_SETUP(T_S), .T_STROBE(T_ST), .T_HOLD(T_H)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_a(ram_a), .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n),
        .ram_di(ram_di), .ram_do(ram_do)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM bank: one bit per part, written while CE_N and WE_N are both low
    logic [RAM_W-1:0]  mem [DEPTH_2147];
    logic              mem_clear = 1'b0;
    logic              flip_en = 1'b0;
    logic [ADDR_W-1:0] flip_addr = '0;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH_2147; i++) mem[i] <= INIT_WORD;
        end else begin
            if (!ram_ce_n && !ram_we_n) mem[ram_a] <= ram_di;
            if (flip_en) mem[flip_addr][RAM_W-1] <= ~mem[flip_addr][RAM_W-1];
        end
    end
    assign ram_do = ram_ce_n ? '0 : mem[ram_a];

    // reference model: word contents as the CPU should see them
    logic [DATA_W-1:0] ref_mem [DEPTH_2147];
    logic [DATA_W-1:0] exp_q[$];

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: one request, then watch the bus and response for a full period
    task automatic do_op(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rdata,
                         input logic exp_err, input string tag, output logic [RAM_W-1:0] di_seen);
        int wait_n, c0, rsp_at, ce_low, we_low, we_bad, a_bad, rsp_cnt;
        logic [DATA_W-1:0] rd;
        logic er;
        di_seen = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        wait_n = 0;
        while (!req_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, " accept"}, 64'(req_ready), 64'(1));
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        c0 = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rsp_at = -1; ce_low = 0; we_low = 0; we_bad = 0; a_bad = 0; rsp_cnt = 0; rd = '0; er = 1'b0;
        for (int k = 1; k <= PERIOD + 3; k++) begin
            @(negedge clk);
            if (!ram_ce_n) begin
                ce_low++;
                di_seen = ram_di;
                if (ram_a !== addr) a_bad++;
            end
            if (!ram_we_n) begin
                we_low++;
                if (ram_ce_n) we_bad++;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_at < 0) begin
                    rsp_at = cyc - c0;
                    rd = rsp_rdata;
                    er = rsp_err;
                end
            end
        end
        check({tag, " latency"}, 64'(rsp_at), 64'(LAT));
        check({tag, " rsp count"}, 64'(rsp_cnt), 64'(1));
        check({tag, " ce_n low cycles"}, 64'(ce_low), 64'(T_ST));
        check({tag, " we_n low cycles"}, 64'(we_low), we ? 64'(T_ST) : 64'(0));
        check({tag, " we_n outside strobe"}, 64'(we_bad), 64'(0));
        check({tag, " ram_a stable"}, 64'(a_bad), 64'(0));
        check({tag, " rdata"}, 64'(rd), 64'(exp_rdata));
        check({tag, " err"}, 64'(er), 64'(exp_err));
        if (we) check({tag, " di"}, 64'(di_seen[DATA_W-1:0]), 64'(wdata));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [RAM_W-1:0]  di;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic [ADDR_W-1:0] b2b_addr [3];
        int acc_cyc [3];
        int n_acc, n_rsp, ready_cnt, rsp_seen;

        vecs[0] = '{1'b1, 12'h123, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 12'h123, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 12'hFFF, 32'hA5A5A5A5, 32'h0};
        vecs[3] = '{1'b1, 12'h000, 32'h5A5A5A5A, 32'h0};
        vecs[4] = '{1'b0, 12'hFFF, 32'h0,        32'hA5A5A5A5};
        vecs[5] = '{1'b0, 12'h000, 32'h0,        32'h5A5A5A5A};
        for (int i = 0; i < DEPTH_2147; i++) ref_mem[i] = '0;

        // reset held three cycles
        mem_clear = 1'b1;
        @(negedge clk);
        mem_clear = 1'b0;
        repeat (2) @(negedge clk);
        check("reset ce_n", 64'(ram_ce_n), 64'(1));
        check("reset we_n", 64'(ram_we_n), 64'(1));
        check("reset req_ready", 64'(req_ready), 64'(1));
        check("reset rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset ram_a", 64'(ram_a), 64'(0));
        check("reset ram_di", 64'(ram_di), 64'(0));
        check("reset rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("reset rsp_err", 64'(rsp_err), 64'(0));
        reset = 1'b0;

        // directed vector table
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b0,
                  $sformatf("vec%0d", i), di);
            if (vecs[i].we) ref_mem[vecs[i].addr] = vecs[i].wdata;
        end

        // random traffic clustered at both ends of the address space
        for (int i = 0; i < 30; i++) begin
            we    = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 3))
                                                : ADDR_W'(12'hFFC + $urandom_range(0, 3));
            wdata = $urandom;
            do_op(we, addr, wdata, we ? '0 : ref_mem[addr], 1'b0, $sformatf("rnd%0d", i), di);
            if (we) ref_mem[addr] = wdata;
        end

        // three reads with req_valid held high
        b2b_addr[0] = 12'h123; b2b_addr[1] = 12'hFFF; b2b_addr[2] = 12'h000;
        for (int i = 0; i < 3; i++) acc_cyc[i] = -100;
        n_acc = 0; n_rsp = 0; ready_cnt = 0;
        exp_q.delete();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = b2b_addr[0];
        for (int k = 0; k < 3 * PERIOD + 6; k++) begin
            if (rsp_valid) begin
                n_rsp++;
                if (exp_q.size() > 0) check("b2b rdata", 64'(rsp_rdata), 64'(exp_q.pop_front()));
            end
            if (req_valid) ready_cnt += int'(req_ready);
            if (req_valid && req_ready) begin
                acc_cyc[n_acc] = cyc;
                exp_q.push_back(ref_mem[req_addr]);
                n_acc++;
            end
            @(posedge clk);
            #1;
            if (n_acc >= 3) req_valid = 1'b0;
            else req_addr = b2b_addr[n_acc];
            @(negedge clk);
        end
        check("b2b 2nd accept offset", 64'(acc_cyc[1] - acc_cyc[0]), 64'(PERIOD));
        check("b2b 3rd accept offset", 64'(acc_cyc[2] - acc_cyc[0]), 64'(2 * PERIOD));
        check("b2b ready cycles", 64'(ready_cnt), 64'(3));
        check("b2b responses", 64'(n_rsp), 64'(3));

        // reset during the second strobe cycle of a read
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h123;
        check("rst accept", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (T_S + T_ST) @(negedge clk);
        check("rst in strobe ce_n", 64'(ram_ce_n), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst ce_n", 64'(ram_ce_n), 64'(1));
        check("rst we_n", 64'(ram_we_n), 64'(1));
        check("rst req_ready", 64'(req_ready), 64'(1));
        check("rst rsp_valid", 64'(rsp_valid), 64'(0));
        rsp_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        check("rst no response", 64'(rsp_seen), 64'(0));

        // parity part: corrupt the stored parity bit and read it back
        do_op(1'b1, 12'h055, 32'h00000001, 32'h0, 1'b0, "par wr", di);
        ref_mem[12'h055] = 32'h00000001;
`ifdef SRAM_PARITY_EN
        check("par di bit", 64'(di[DATA_W]), 64'(0));
        @(negedge clk);
        flip_addr = 12'h055;
        flip_en = 1'b1;
        @(negedge clk);
        flip_en = 1'b0;
        do_op(1'b0, 12'h055, 32'h0, 32'h00000001, 1'b1, "par rd", di);
`else
        do_op(1'b0, 12'h055, 32'h0, 32'h00000001, 1'b0, "par rd", di);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
